mul_div_iter: RTL and testbench
===============================

Name: mul_div_iter

Overview:
- Iterative unsigned multiply/divide unit for the 32-bit datapath. One shift-add or restoring-divide step per clock.
- Sits in the execute stage. Its lo/hi results feed the write-back select multiplexer as one data input.
- Uses a start/busy/done handshake so the pipeline control can stall while an operation is in flight.

Parameters:
- N, 32, operand and result width in bits. Must be at least 2. The iteration counter is $clog2(N)+1 bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only when accepted (see Behaviour).
- op  input  1  0 = unsigned multiply, 1 = unsigned divide.
- a  input  N  multiplicand / dividend.
- b  input  N  multiplier / divisor.
- busy  output  1  high while an operation is iterating.
- done  output  1  one-cycle pulse when hi/lo/dbz are updated.
- lo  output  N  multiply: low half of product. Divide: quotient.
- hi  output  N  multiply: high half of product. Divide: remainder.
- dbz  output  1  set when the last divide had b == 0.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0, dbz = 0.
  - lo = 0, hi = 0.
  - Internal operand, accumulator and counter registers cleared.
- States: IDLE, RUN, DONE.
- Accept rule: start is accepted at an edge where start = 1 and state is IDLE or DONE.
  - On accept, a, b and op are latched. Later changes on a, b, op and start are ignored until the operation completes.
  - start = 1 in RUN is ignored; no queuing.
- IDLE:
  - If not accepting, stay in IDLE.
  - On accept with op = 1 and b == 0, go to DONE at the next edge.
  - On any other accept, go to RUN with counter = 0.
- RUN:
  - busy = 1.
  - One iteration per cycle. The counter increments each cycle.
  - After exactly N RUN cycles, go to DONE.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - hi, lo and dbz take their new values in this same cycle.
  - Next state: RUN (or DONE again for a divide by zero) if a new start is accepted; otherwise IDLE.
- Latency:
  - start accepted at edge t: done is high in cycle t+N+1, i.e. N RUN cycles plus one DONE cycle.
  - Divide by zero: done is high in cycle t+1.
  - Back-to-back starts (start held high) give one result every N+1 cycles.
- Multiply: {hi, lo} = a * b, full 2N-bit unsigned product, no truncation.
- Divide (b != 0):
  - lo = floor(a / b), hi = a mod b, unsigned restoring algorithm.
  - Invariant: lo*b + hi == a and hi < b.
- Divide by zero: lo = all ones, hi = a, dbz = 1.
- dbz is 0 after any multiply or nonzero-divisor divide. It changes only together with hi/lo.
- Output holding:
  - hi, lo and dbz hold their last completed values through IDLE and through subsequent RUN cycles.
  - Intermediate accumulator values are never visible on hi/lo.
- Reset mid-operation: rst = 1 in any state forces IDLE and reset values at that edge. The in-flight operation is discarded and no done pulse is produced. rst has priority over start.
- Edge cases:
  - a = 0 or b = 0 for multiply: full N-cycle run, result 0.
  - a < b for divide: lo = 0, hi = a.

Test Plan:
- Multiply, latency: rst 2 cycles, then start with op=0, a=7, b=6 for one cycle. Required: busy high 32 cycles, then done high for one cycle with lo=42, hi=0, dbz=0. Done appears exactly 33 cycles after the accepting edge.
- Max multiply: a=0xFFFFFFFF, b=0xFFFFFFFF, op=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Divide, with operand changes and a busy start: op=1, a=100, b=7 -> lo=14, hi=2, dbz=0. Change a/b during RUN and pulse start mid-RUN; both are ignored, results unchanged and timing unchanged.
- Divide by zero: op=1, a=5, b=0 -> done one cycle after accept, lo=0xFFFFFFFF, hi=5, dbz=1. A following multiply 3*3 clears dbz, giving lo=9.
- Back-to-back: start held high with op=1, a=0x80000000, b=3 -> done pulses every 33 cycles, each with lo=0x2AAAAAAA, hi=2. busy is low only in the done cycles.
- Reset mid-op: assert rst at RUN cycle 10 of a multiply. At the next edge busy=0, done=0, lo=hi=0, and no done pulse follows. A subsequent operation completes normally.

Source files
------------

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one step per clock.
// Results appear on hi/lo with a one-cycle done pulse; start/busy let the pipeline stall.
module mul_div_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi,
    output logic         dbz
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic          op_r;
    logic [N-1:0]  opnd;
    logic [N-1:0]  acc;
    logic [N-1:0]  lsr;
    logic [CW-1:0] cnt;

    logic [N:0]    mul_sum;
    logic [N+1:0]  div_diff;
    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  lsr_nxt;

    // Multiply: acc:lsr is the product shifting right, lsr starts as the multiplier.
    // Divide: acc is the partial remainder, lsr shifts the dividend out and the quotient in.
    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        mul_sum  = {1'b0, acc} + (lsr[0] ? {1'b0, opnd} : '0);
        div_diff = {1'b0, acc, lsr[N-1]} - {2'b00, opnd};
        if (op_r) begin
            acc_nxt = div_diff[N+1] ? {acc[N-2:0], lsr[N-1]} : div_diff[N-1:0];
            lsr_nxt = {lsr[N-2:0], ~div_diff[N+1]};
        end else begin
            acc_nxt = mul_sum[N:1];
            lsr_nxt = {mul_sum[0], lsr[N-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
            lo    <= '0;
            hi    <= '0;
            op_r  <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            lsr   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_r <= op;
                        opnd <= op ? b : a;
                        lsr  <= op ? a : b;
                        acc  <= '0;
                        cnt  <= '0;
                        if (op && (b == '0)) begin
                            // Divide by zero short-circuits straight to a result.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            lo    <= '1;
                            hi    <= a;
                            dbz   <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    lsr <= lsr_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= acc_nxt;
                        lo    <= lsr_nxt;
                        dbz   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_iter.sv
// Bench for mul_div_iter: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_mul_div_iter;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic         dbz;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    bit seen;
    bit armed = 1'b0;

    mul_div_iter #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .lo    (lo),
        .hi    (hi),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining-cycle countdown plus a result computed with plain arithmetic.
    int           m_left = 0;
    logic [63:0]  m_pend;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [N-1:0] m_lo   = '0;
    logic [N-1:0] m_hi   = '0;
    logic         m_dbz  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            armed  = 1'b1;
            m_left = 0;
            m_done = 1'b0;
            m_lo   = '0;
            m_hi   = '0;
            m_dbz  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done       = 1'b1;
                    {m_hi, m_lo} = m_pend;
                    m_dbz        = 1'b0;
                end
            end else if (start) begin
                if (op && b == 0) begin
                    m_done = 1'b1;
                    m_lo   = '1;
                    m_hi   = a;
                    m_dbz  = 1'b1;
                end else begin
                    m_left = N;
                    m_pend = op ? {a % b, a / b} : 64'(a) * 64'(b);
                end
            end
        end
        m_busy = (m_left > 0);
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("lo", lo, m_lo);
            check("hi", hi, m_hi);
            check("dbz", dbz, m_dbz);
        end
    end

    task automatic drive(input logic o, input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Counts cycles after the accepting edge until done, bounded.
    task automatic wait_done(input bit hold);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
        end while (!done && cyc < 60);
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_lo", lo, 64'd0);
        check("rst_busy", busy, 64'd0);
        rst = 1'b0;

        drive(1'b0, 32'd7, 32'd6);
        wait_done(1'b0);
        check("mul7x6_lat", cyc, 64'd33);
        check("mul7x6_lo", lo, 64'd42);
        check("mul7x6_hi", hi, 64'd0);
        check("mul7x6_dbz", dbz, 64'd0);

        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0);
        check("mulmax_hi", hi, 64'hFFFF_FFFE);
        check("mulmax_lo", lo, 64'h0000_0001);

        drive(1'b0, 32'd0, 32'd12345);
        wait_done(1'b0);
        check("mul0_lat", cyc, 64'd33);
        check("mul0_lo", lo, 64'd0);

        // Operand changes and a stray start while running must be ignored.
        drive(1'b1, 32'd100, 32'd7);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == 10);
            if (cyc == 5) begin
                a  = 32'd999;
                b  = 32'd0;
                op = 1'b0;
            end
        end while (!done && cyc < 60);
        check("div100_lat", cyc, 64'd33);
        check("div100_lo", lo, 64'd14);
        check("div100_hi", hi, 64'd2);
        check("div100_dbz", dbz, 64'd0);

        drive(1'b1, 32'd5, 32'd9);
        wait_done(1'b0);
        check("div_small_lo", lo, 64'd0);
        check("div_small_hi", hi, 64'd5);

        drive(1'b1, 32'd5, 32'd0);
        wait_done(1'b0);
        check("dbz_lat", cyc, 64'd1);
        check("dbz_lo", lo, 64'hFFFF_FFFF);
        check("dbz_hi", hi, 64'd5);
        check("dbz_flag", dbz, 64'd1);

        drive(1'b0, 32'd3, 32'd3);
        wait_done(1'b0);
        check("mul3x3_lo", lo, 64'd9);
        check("mul3x3_dbz", dbz, 64'd0);

        drive(1'b1, 32'h8000_0000, 32'd3);
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b1);
            check("b2b_lat", cyc, 64'd33);
            check("b2b_lo", lo, 64'h2AAA_AAAA);
            check("b2b_hi", hi, 64'd2);
        end
        start = 1'b0;

        drive(1'b0, 32'd123, 32'd456);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_busy", busy, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 64'd0);
        check("mid_rst_done", done, 64'd0);
        check("mid_rst_lo", lo, 64'd0);
        check("mid_rst_hi", hi, 64'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("no_done_after_rst", {63'd0, seen}, 64'd0);

        drive(1'b1, 32'd1000, 32'd33);
        wait_done(1'b0);
        check("post_rst_lat", cyc, 64'd33);
        check("post_rst_lo", lo, 64'd30);
        check("post_rst_hi", hi, 64'd10);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
